l2_banked_spm: RTL and testbench

Parametrised, word-interleaved, multi-port L2 scratchpad with built-in per-bank round-robin arbitration and configurable response latency.
- Adds a per-port address base, an out-of-range error response and optional bank-conflict performance counters.
- Sits between the AXI-to-TCDM bridge ports plus uDMA TCDM channels and the L2 SRAM banks.
- Replaces the fixed 6-port/4-bank L2 arrangement.

---
 rtl/l2_spm_pkg.sv | 36 +++
 rtl/l2_bank_rr_arb.sv | 47 ++++
 rtl/l2_banked_spm.sv | 242 ++++++++++++++++++++++++
 tb/tb_l2_banked_spm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_spm_pkg.sv
// Shared opcodes, response-pipeline record and address decode for the banked L2 scratchpad.
package l2_spm_pkg;

   localparam logic L2_OPC_OK  = 1'b0;
   localparam logic L2_OPC_ERR = 1'b1;

   // Wide enough for up to 256 banks; the top compares the full field.
   localparam int unsigned L2_BANK_ID_W = 8;

   typedef struct packed {
      logic                    valid;
      logic                    opc;
      logic [L2_BANK_ID_W-1:0] bank;
   } l2_resp_t;

   typedef struct packed {
      logic        oor;
      logic [31:0] bank;
      logic [31:0] row;
   } l2_dec_t;

   // Word-interleaved decode of a base-relative byte offset.
   function automatic l2_dec_t addr_decode(input logic [31:0]  off,
                                           input int unsigned  word_sh,
                                           input int unsigned  bank_w,
                                           input logic [63:0]  span);
      l2_dec_t     d;
      logic [31:0] word;
      word   = off >> word_sh;
      d.oor  = ({32'd0, off} >= span);
      d.bank = word & ((32'd1 << bank_w) - 32'd1);
      d.row  = word >> bank_w;
      return d;
   endfunction

endpackage

// File: rtl/l2_bank_rr_arb.sv
// Round-robin arbiter for one L2 bank: one-hot grant plus winner index.
module l2_bank_rr_arb #(
   parameter int unsigned NumPorts = 6,
   localparam int unsigned IdxW    = $clog2(NumPorts)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumPorts-1:0] req_i,
   output logic [NumPorts-1:0] gnt_o,
   output logic [IdxW-1:0]     idx_o,
   output logic                vld_o
);

   logic [IdxW-1:0] ptr_q;
   logic [IdxW:0]   sum;
   logic [IdxW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      sum   = '0;
      cand  = '0;
      // Scan ports starting at the pointer, wrapping modulo NumPorts.
      for (int i = 0; i < NumPorts; i++) begin
         sum = {1'b0, ptr_q} + (IdxW+1)'(i);
         if (sum >= (IdxW+1)'(NumPorts)) begin
            sum = sum - (IdxW+1)'(NumPorts);
         end
         cand = sum[IdxW-1:0];
         if (!vld_o && req_i[cand]) begin
            vld_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else if (vld_o) begin
         ptr_q <= (idx_o == IdxW'(NumPorts-1)) ? '0 : idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/l2_banked_spm.sv
// Word-interleaved multi-port L2 scratchpad with per-bank round-robin arbitration.
// Optional conflict counters under L2_PERF_CNT_EN; ASIC SRAM macros under TARGET_ASIC.
module l2_banked_spm
   import l2_spm_pkg::*;
#(
   parameter int unsigned                  NumPorts   = 6,
   parameter int unsigned                  NumBanks   = 4,
   parameter int unsigned                  BankWords  = 32768,
   parameter int unsigned                  DataWidth  = 32,
   parameter int unsigned                  MemLatency = 1,
   parameter logic [NumPorts-1:0][31:0]    PortBase   = {NumPorts{32'h1C00_0000}}
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumPorts-1:0]                  req_i,
   input  logic [NumPorts-1:0][31:0]            add_i,
   input  logic [NumPorts-1:0]                  wen_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
   input  logic [NumPorts-1:0][DataWidth/8-1:0] be_i,
   output logic [NumPorts-1:0]                  gnt_o,
   output logic [NumPorts-1:0]                  r_valid_o,
   output logic [NumPorts-1:0][DataWidth-1:0]   r_rdata_o,
   output logic [NumPorts-1:0]                  r_opc_o,
   input  logic                                 perf_clr_i,
   output logic [NumBanks-1:0][31:0]            perf_conflict_o
);

   localparam int unsigned ByteW  = DataWidth / 8;
   localparam int unsigned BankW  = $clog2(NumBanks);
   localparam int unsigned RowW   = $clog2(BankWords);
   localparam int unsigned IdxW   = $clog2(NumPorts);
   localparam int unsigned WordSh = $clog2(ByteW);
   localparam logic [63:0] SpanB  = 64'(NumBanks) * 64'(BankWords) * 64'(ByteW);

   l2_dec_t                            dec [NumPorts];
   logic [NumPorts-1:0][RowW-1:0]      row_sel;
   logic [NumBanks-1:0][NumPorts-1:0]  arb_req;
   logic [NumBanks-1:0][NumPorts-1:0]  arb_gnt;
   logic [NumBanks-1:0][IdxW-1:0]      arb_idx;
   logic [NumBanks-1:0]                arb_vld;

   always_comb begin
      arb_req = '0;
      for (int p = 0; p < NumPorts; p++) begin
         dec[p]     = addr_decode(add_i[p] - PortBase[p], WordSh, BankW, SpanB);
         row_sel[p] = dec[p].row[RowW-1:0];
         for (int b = 0; b < NumBanks; b++) begin
            arb_req[b][p] = req_i[p] & ~dec[p].oor & (dec[p].bank == 32'(b));
         end
      end
   end

   for (genvar b = 0; b < NumBanks; b++) begin : g_arb
      l2_bank_rr_arb #(
         .NumPorts (NumPorts)
      ) i_arb (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .req_i  (arb_req[b]),
         .gnt_o  (arb_gnt[b]),
         .idx_o  (arb_idx[b]),
         .vld_o  (arb_vld[b])
      );
   end

   // Out-of-range requests bypass arbitration; everything is masked in reset.
   always_comb begin
      gnt_o = '0;
      for (int p = 0; p < NumPorts; p++) begin
         gnt_o[p] = rst_ni & req_i[p] & dec[p].oor;
      end
      for (int b = 0; b < NumBanks; b++) begin
         gnt_o = gnt_o | (arb_gnt[b] & {NumPorts{rst_ni}});
      end
   end

   logic [NumBanks-1:0]                bank_en;
   logic [NumBanks-1:0]                bank_we;
   logic [NumBanks-1:0][RowW-1:0]      bank_row;
   logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;
   logic [NumBanks-1:0][ByteW-1:0]     bank_be;

   always_comb begin
      for (int b = 0; b < NumBanks; b++) begin
         bank_en[b]    = rst_ni & arb_vld[b];
         bank_we[b]    = ~wen_i[arb_idx[b]];
         bank_row[b]   = row_sel[arb_idx[b]];
         bank_wdata[b] = wdata_i[arb_idx[b]];
         bank_be[b]    = be_i[arb_idx[b]];
      end
   end

   // ---- stage p0: SRAM access, response control captured at the grant edge ----
   logic [NumBanks-1:0][DataWidth-1:0] bank_rdata_p0;
   logic [NumBanks-1:0]                bank_rd_p0;

   for (genvar b = 0; b < NumBanks; b++) begin : g_bank
`ifdef TARGET_ASIC
      tc_sram_gf22 #(
         .NumWords  (BankWords),
         .DataWidth (DataWidth)
      ) i_sram (
         .clk_i   (clk_i),
         .req_i   (bank_en[b]),
         .we_i    (bank_we[b]),
         .addr_i  (bank_row[b]),
         .wdata_i (bank_wdata[b]),
         .be_i    (bank_be[b]),
         .rdata_o (bank_rdata_p0[b])
      );
`else
      logic [DataWidth-1:0] mem [BankWords];
      logic [DataWidth-1:0] rdata_q;

      always_ff @(posedge clk_i) begin
         if (bank_en[b]) begin
            if (bank_we[b]) begin
               for (int i = 0; i < ByteW; i++) begin
                  if (bank_be[b][i]) begin
                     mem[bank_row[b]][8*i +: 8] <= bank_wdata[b][8*i +: 8];
                  end
               end
            end else begin
               rdata_q <= mem[bank_row[b]];
            end
         end
      end

      assign bank_rdata_p0[b] = rdata_q;
`endif
   end

   l2_resp_t [NumPorts-1:0] resp_p0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         resp_p0    <= '0;
         bank_rd_p0 <= '0;
      end else begin
         bank_rd_p0 <= bank_en & ~bank_we;
         for (int p = 0; p < NumPorts; p++) begin
            resp_p0[p].valid <= gnt_o[p];
            resp_p0[p].opc   <= dec[p].oor ? L2_OPC_ERR : L2_OPC_OK;
            resp_p0[p].bank  <= L2_BANK_ID_W'(dec[p].bank);
         end
      end
   end

   // Steer each bank's read word to the port it served; writes and errors yield 0.
   logic [NumPorts-1:0][DataWidth-1:0] rdata_p0;

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         rdata_p0[p] = '0;
         for (int b = 0; b < NumBanks; b++) begin
            if (resp_p0[p].valid && (resp_p0[p].opc == L2_OPC_OK) && bank_rd_p0[b] &&
                (resp_p0[p].bank == L2_BANK_ID_W'(b))) begin
               rdata_p0[p] = bank_rdata_p0[b];
            end
         end
      end
   end

   l2_resp_t [NumPorts-1:0]            resp_out;
   logic [NumPorts-1:0][DataWidth-1:0] rdata_out;

   // ---- stages p1..: MemLatency-1 delay registers ----
   if (MemLatency > 1) begin : g_pipe
      l2_resp_t [NumPorts-1:0]            resp_pn  [MemLatency-1];
      logic [NumPorts-1:0][DataWidth-1:0] rdata_pn [MemLatency-1];

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            for (int k = 0; k < MemLatency-1; k++) begin
               resp_pn[k] <= '0;
            end
         end else begin
            resp_pn[0] <= resp_p0;
            for (int k = 1; k < MemLatency-1; k++) begin
               resp_pn[k] <= resp_pn[k-1];
            end
         end
      end

      always_ff @(posedge clk_i) begin
         rdata_pn[0] <= rdata_p0;
         for (int k = 1; k < MemLatency-1; k++) begin
            rdata_pn[k] <= rdata_pn[k-1];
         end
      end

      assign resp_out  = resp_pn[MemLatency-2];
      assign rdata_out = rdata_pn[MemLatency-2];
   end else begin : g_nopipe
      assign resp_out  = resp_p0;
      assign rdata_out = rdata_p0;
   end

   logic unused_bits;

   always_comb begin
      unused_bits = 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
         r_valid_o[p] = resp_out[p].valid;
         r_opc_o[p]   = resp_out[p].valid & resp_out[p].opc;
         r_rdata_o[p] = resp_out[p].valid ? rdata_out[p] : '0;
         unused_bits  = unused_bits ^ (^resp_out[p].bank) ^ (^dec[p].row[31:RowW]);
      end
   end

`ifdef L2_PERF_CNT_EN
   logic [NumBanks-1:0][31:0] perf_cnt_q;
   logic [NumBanks-1:0]       conflict;

   always_comb begin
      for (int b = 0; b < NumBanks; b++) begin
         conflict[b] = (arb_req[b] & (arb_req[b] - {{(NumPorts-1){1'b0}}, 1'b1})) != '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_cnt_q <= '0;
      end else begin
         for (int b = 0; b < NumBanks; b++) begin
            if (perf_clr_i) begin
               perf_cnt_q[b] <= '0;
            end else if (conflict[b] && (perf_cnt_q[b] != '1)) begin
               perf_cnt_q[b] <= perf_cnt_q[b] + 32'd1;
            end
         end
      end
   end

   assign perf_conflict_o = perf_cnt_q;
`else
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr_i;
   assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_l2_banked_spm.sv
// Directed table-driven bench for l2_banked_spm (latency 1 and latency 3 instances).
module tb_l2_banked_spm;

   localparam int NP = 6;
   localparam int NB = 4;
   localparam int DW = 32;
`ifdef L2_PERF_CNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n, perf_clr;
   logic [NP-1:0]            req, wen, gnt, rv, opc;
   logic [NP-1:0][31:0]      add;
   logic [NP-1:0][DW-1:0]    wdata, rdata;
   logic [NP-1:0][3:0]       be;
   logic [NB-1:0][31:0]      perf;

   logic                     rst3_n;
   logic [NP-1:0]            req3, wen3, gnt3, rv3, opc3;
   logic [NP-1:0][31:0]      add3;
   logic [NP-1:0][DW-1:0]    wdata3, rdata3;
   logic [NP-1:0][3:0]       be3;
   logic [NB-1:0][31:0]      perf3;

   l2_banked_spm #(.NumPorts(NP), .NumBanks(NB), .MemLatency(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
      .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(rv), .r_rdata_o(rdata),
      .r_opc_o(opc), .perf_clr_i(perf_clr), .perf_conflict_o(perf)
   );

   l2_banked_spm #(.NumPorts(NP), .NumBanks(NB), .MemLatency(3)) dut3 (
      .clk_i(clk), .rst_ni(rst3_n), .req_i(req3), .add_i(add3), .wen_i(wen3),
      .wdata_i(wdata3), .be_i(be3), .gnt_o(gnt3), .r_valid_o(rv3), .r_rdata_o(rdata3),
      .r_opc_o(opc3), .perf_clr_i(1'b0), .perf_conflict_o(perf3)
   );

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_opc;
   } vec_t;

   vec_t vt [13];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle();
      req = '0; wen = '1; add = '0; wdata = '0; be = '0;
   endtask

   task automatic idle3();
      req3 = '0; wen3 = '1; add3 = '0; wdata3 = '0; be3 = '0;
   endtask

   logic [NP-1:0] exp_g, pend;
   logic [NP-1:0] cexp [3];
   vec_t          pv;

   initial begin
      vt[0]  = '{0,  32'h1C00_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
      vt[1]  = '{0,  32'h1C00_0010, 1'b1, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
      vt[2]  = '{1,  32'h1C00_0014, 1'b0, 32'hAABB_CCDD, 4'hF, 32'h0,         1'b0};
      vt[3]  = '{1,  32'h1C00_0014, 1'b0, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
      vt[4]  = '{2,  32'h1C00_0014, 1'b1, 32'h0,         4'hF, 32'hAA22_CC44, 1'b0};
      vt[5]  = '{3,  32'h1C00_0014, 1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
      vt[6]  = '{3,  32'h1C00_0014, 1'b1, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0};
      vt[7]  = '{4,  32'h1C08_0000, 1'b1, 32'h0,         4'hF, 32'h0,         1'b1};
      vt[8]  = '{4,  32'h1C08_0010, 1'b0, 32'h5555_5555, 4'hF, 32'h0,         1'b1};
      vt[9]  = '{0,  32'h1C00_0010, 1'b1, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
      vt[10] = '{5,  32'h1BFF_FFFC, 1'b1, 32'h0,         4'hF, 32'h0,         1'b1};
      vt[11] = '{5,  32'h1C07_FFFC, 1'b0, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0};
      vt[12] = '{5,  32'h1C07_FFFC, 1'b1, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0};

      rst_n = 1'b0; rst3_n = 1'b0; perf_clr = 1'b0;
      idle(); idle3();
      req[0] = 1'b1; add[0] = 32'h1C00_0000;
      step(); step(); mid();
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_rvalid", 64'(rv), 64'h0);
      chk("rst_opc", 64'(opc), 64'h0);
      chk("rst_rdata", 64'(|rdata), 64'h0);
      chk("rst_perf", 64'(|perf), 64'h0);

      step();
      rst_n = 1'b1; rst3_n = 1'b1; idle();

      // Single-port transactions, issued back to back
      for (int i = 0; i <= 13; i++) begin
         step();
         idle();
         if (i < 13) begin
            req[vt[i].port]   = 1'b1;
            add[vt[i].port]   = vt[i].addr;
            wen[vt[i].port]   = vt[i].wen;
            wdata[vt[i].port] = vt[i].wdata;
            be[vt[i].port]    = vt[i].be;
         end
         mid();
         if (i < 13) begin
            exp_g = '0; exp_g[vt[i].port] = 1'b1;
            chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(exp_g));
         end
         if (i > 0) begin
            pv = vt[i-1];
            exp_g = '0; exp_g[pv.port] = 1'b1;
            chk($sformatf("v%0d_rvalid", i-1), 64'(rv), 64'(exp_g));
            chk($sformatf("v%0d_rdata", i-1), 64'(rdata[pv.port]), 64'(pv.exp_rdata));
            chk($sformatf("v%0d_opc", i-1), 64'(opc[pv.port]), 64'(pv.exp_opc));
         end
      end

      // Four ports, four banks, same cycle: writes then reads
      step(); idle();
      for (int k = 0; k < 4; k++) begin
         req[k] = 1'b1; wen[k] = 1'b0; be[k] = 4'hF;
         add[k] = 32'h1C00_0000 + 32'(4*k); wdata[k] = 32'hA000_0000 + 32'(k);
      end
      mid();
      chk("par_wr_gnt", 64'(gnt), 64'h0F);
      step();
      for (int k = 0; k < 4; k++) wen[k] = 1'b1;
      mid();
      chk("par_rd_gnt", 64'(gnt), 64'h0F);
      chk("par_wr_rvalid", 64'(rv), 64'h0F);
      chk("par_wr_rdata", 64'(|rdata), 64'h0);
      step(); idle(); mid();
      chk("par_rd_rvalid", 64'(rv), 64'h0F);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("par_rd_rdata%0d", k), 64'(rdata[k]), 64'(32'hA000_0000 + 32'(k)));
      end

      // Reset returns the pointers to 0 but keeps SRAM contents
      step(); rst_n = 1'b0; mid();
      step(); rst_n = 1'b1;

      // Ports 0/2/5 contend for bank 1; port 1 hits bank 2 in parallel
      cexp[0] = 6'b000011; cexp[1] = 6'b000100; cexp[2] = 6'b100000;
      pend = 6'b100101;
      add[0] = 32'h1C00_0004; add[2] = 32'h1C00_0014; add[5] = 32'h1C00_0024;
      add[1] = 32'h1C00_0008;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) step();
         req = pend;
         req[1] = (c == 0);
         mid();
         chk($sformatf("arb_c%0d_gnt", c), 64'(gnt), 64'(cexp[c]));
         if (c > 0) chk($sformatf("arb_c%0d_rvalid", c), 64'(rv), 64'(cexp[c-1]));
         if (c == 2) chk("arb_p2_rdata", 64'(rdata[2]), 64'h0000_0000_AA22_CC44);
         pend = pend & ~cexp[c];
      end
      step();
      req = 6'b100100;
      mid();
      chk("arb_wrap_gnt", 64'(gnt), 64'h04);
      chk("arb_c3_rvalid", 64'(rv), 64'h20);
      step(); idle(); mid();
      chk("arb_wrap_rvalid", 64'(rv), 64'h04);

      // Conflict counters on bank 3
      step(); perf_clr = 1'b1; mid();
      step(); perf_clr = 1'b0; mid();
      chk("perf_clr0_b1", 64'(perf[1]), 64'h0);
      req[0] = 1'b1; add[0] = 32'h1C00_000C;
      req[1] = 1'b1; add[1] = 32'h1C00_001C;
      repeat (10) step();
      perf_clr = 1'b1;
      mid();
      chk("perf_b3_10", 64'(perf[3]), PERF_EN ? 64'd10 : 64'd0);
      for (int b = 0; b < 3; b++) chk($sformatf("perf_b%0d_0", b), 64'(perf[b]), 64'h0);
      step(); perf_clr = 1'b0; mid();
      chk("perf_clr_prio", 64'(perf[3]), 64'h0);
      step(); idle(); mid();
      chk("perf_after_clr", 64'(perf[3]), PERF_EN ? 64'd1 : 64'd0);

      // Latency-3 instance: write timing
      step();
      req3[1] = 1'b1; add3[1] = 32'h1C00_0020; wen3[1] = 1'b0;
      wdata3[1] = 32'hCAFE_F00D; be3[1] = 4'hF;
      mid();
      chk("l3_wr_gnt", 64'(gnt3), 64'h02);
      step(); idle3(); mid();
      chk("l3_wr_rv1", 64'(rv3), 64'h0);
      step(); mid();
      chk("l3_wr_rv2", 64'(rv3), 64'h0);
      step(); mid();
      chk("l3_wr_rv3", 64'(rv3), 64'h02);
      chk("l3_wr_opc", 64'(opc3[1]), 64'h0);
      chk("l3_wr_rdata", 64'(rdata3[1]), 64'h0);

      // Back-to-back reads cut by a one-cycle reset in cycle 2
      for (int c = 0; c < 7; c++) begin
         step();
         idle3();
         rst3_n = (c != 2);
         if (c < 4) begin
            req3[1] = 1'b1; add3[1] = 32'h1C00_0020; wen3[1] = 1'b1;
         end
         mid();
         if (c < 4) chk($sformatf("l3_c%0d_gnt", c), 64'(gnt3), (c == 2) ? 64'h0 : 64'h02);
         if (c >= 3 && c <= 5) begin
            chk($sformatf("l3_c%0d_rvalid", c), 64'(rv3), 64'h0);
            chk($sformatf("l3_c%0d_rdata", c), 64'(|rdata3), 64'h0);
         end
         if (c == 6) begin
            chk("l3_c6_rvalid", 64'(rv3), 64'h02);
            chk("l3_c6_rdata", 64'(rdata3[1]), 64'h0000_0000_CAFE_F00D);
            chk("l3_c6_opc", 64'(opc3[1]), 64'h0);
         end
      end
      step(); mid();
      chk("l3_tail_rvalid", 64'(rv3), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
